// File: rtl/bs_pkg.sv
// Shared types and constants for the Black-Scholes operand server and its controller.
package bs_pkg;

  localparam int DATASIZE = 192;
  localparam int BSMODS   = 2;

  typedef logic [DATASIZE-1:0] bs_record_t;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT,
    DONE
  } srv_state_t;

endpackage

// File: rtl/bs_operand_server_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last granted requester.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = last;
    idx       = last;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer starts at the top slot so slot 0 wins the first arbitration.
  always_ff @(posedge clock) begin
    if (reset)
      last <= IDX_W'(N - 1);
    else if (advance && found)
      last <= grant_idx;
  end

endmodule

// File: rtl/bs_operand_server.sv
// Operand server feeding the Black-Scholes controller from a synchronous-read record memory.
// Optional BS_SERVER_STATS_EN adds a saturating stall_cycles counter output.
module bs_operand_server #(
  parameter int BSMODS   = 2,
  parameter int DATASIZE = 192,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W:0]            rec_count,
  input  logic [BSMODS-1:0]          SERVE_REG,
  input  logic [BSMODS-1:0]          BS_START,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATASIZE-1:0]        mem_rdata,
  output logic [BSMODS*DATASIZE-1:0] operand,
  output logic [BSMODS-1:0]          hasUnusedData,
  output logic [BSMODS-1:0]          REG_READY,
  output logic                       OutOfData,
`ifdef BS_SERVER_STATS_EN
  output logic [15:0]                stall_cycles,
`endif
  output logic                       busy
);

  import bs_pkg::*;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  srv_state_t        state, state_nx;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   remaining;
  logic [BSMODS-1:0] pending;
  logic [BSMODS-1:0] gnt;
  logic [BSMODS-1:0] arb_grant;
  logic [BSMODS-1:0] issue_mask;
  logic [BSMODS-1:0] fill_mask;
  logic [BSMODS-1:0] inflight;
  logic [BSMODS-1:0] req_ok;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_last;
  logic              drain;
  logic              arb_adv;

  assign wait_last  = (wait_cnt == CNT_W'(RD_LAT - 1));
  assign drain      = (state == ARB) && (remaining == '0);
  assign arb_adv    = (state == ARB) && !drain && (|pending);
  assign issue_mask = (state == ISSUE) ? gnt : '0;
  assign fill_mask  = (state == WAIT && wait_last) ? gnt : '0;
  assign inflight   = (state == ISSUE || state == WAIT) ? gnt : '0;
  // A slot may only queue a request when it is empty, not being filled, and data remains.
  assign req_ok     = SERVE_REG & ~hasUnusedData & ~inflight & {BSMODS{~OutOfData}};

  assign mem_en   = (state == ISSUE);
  assign mem_addr = next_addr;

  rr_arbiter #(.N(BSMODS)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (pending),
    .advance (arb_adv),
    .grant   (arb_grant)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load) state_nx = ARB;
      ARB:     if (drain) state_nx = DONE;
               else if (|pending) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wait_last) state_nx = ARB;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      next_addr     <= '0;
      remaining     <= '0;
      pending       <= '0;
      gnt           <= '0;
      wait_cnt      <= '0;
      operand       <= '0;
      hasUnusedData <= '0;
      REG_READY     <= '1;
      OutOfData     <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      hasUnusedData <= (hasUnusedData & ~BS_START) | fill_mask;
      REG_READY     <= (REG_READY & ~issue_mask) | fill_mask;

      if (drain)
        pending <= '0;
      else
        pending <= (pending | req_ok) & ~issue_mask;

      if (arb_adv)
        gnt <= arb_grant;

      if (state == IDLE && load) begin
        next_addr <= base_addr;
        remaining <= rec_count;
        busy      <= 1'b1;
        OutOfData <= 1'b0;
      end

      if (drain)
        OutOfData <= 1'b1;

      if (state == ISSUE) begin
        next_addr <= next_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      // Only one read is ever outstanding, so DONE never has a return to wait for.
      if (state == DONE)
        busy <= 1'b0;

      for (int i = 0; i < BSMODS; i++)
        if (fill_mask[i])
          operand[i*DATASIZE +: DATASIZE] <= mem_rdata;
    end
  end

`ifdef BS_SERVER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset)
      stall_cycles <= '0;
    else if (state == IDLE && load)
      stall_cycles <= '0;
    else if ((|pending) && state != ARB)
      stall_cycles <= sat_inc16(stall_cycles);
  end
`endif

endmodule
